// File: rtl/imm_narrow_pkg.sv
// imm_narrow_pkg: shared widths, buffer states and the 16-to-6 fit/narrow function.
package imm_narrow_pkg;
  localparam int DEF_IN_W = 16;
  localparam int DEF_OUT_W = 6;
  localparam logic [DEF_OUT_W-1:0] SAT_POS = {1'b0, {(DEF_OUT_W-1){1'b1}}};
  localparam logic [DEF_OUT_W-1:0] SAT_NEG = {1'b1, {(DEF_OUT_W-1){1'b0}}};
  typedef enum logic [1:0] {EMPTY, ONE, TWO} buf_state_t;
  // Returns {ovf, field}; a value fits when all bits above the field's sign bit match it.
  function automatic logic [DEF_OUT_W:0] narrow(input logic [DEF_IN_W-1:0] d, input logic sat);
    logic [DEF_IN_W-DEF_OUT_W:0] hi;
    logic fit;
    hi = d[DEF_IN_W-1:DEF_OUT_W-1];
    fit = &hi | ~|hi;
    return {~fit, (fit | ~sat) ? d[DEF_OUT_W-1:0] : (d[DEF_IN_W-1] ? SAT_NEG : SAT_POS)};
  endfunction
endpackage

// File: rtl/narrow_skid_buf.sv
// narrow_skid_buf: 2-entry skid buffer, in_ready depends only on the state register.
module narrow_skid_buf
  import imm_narrow_pkg::*;
#(
  parameter int W = DEF_OUT_W + 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  buf_state_t state;
  logic [W-1:0] head, tail;
  logic push, pop;
  assign in_ready = state != TWO;
  assign out_valid = state != EMPTY;
  assign out_data = head;
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= EMPTY;
      head <= '0;
      tail <= '0;
    end else begin
      case (state)
        EMPTY: if (push) begin
          head <= in_data;
          state <= ONE;
        end
        ONE: if (push & pop) head <= in_data;
          else if (push) begin
            tail <= in_data;
            state <= TWO;
          end else if (pop) state <= EMPTY;
        default: if (pop) begin
          head <= tail;
          state <= ONE;
        end
      endcase
    end
  end
endmodule

// File: rtl/imm_narrow_16to6.sv
// imm_narrow_16to6: narrows signed 16-bit values to 6-bit immediates with overflow flag and count.
module imm_narrow_16to6
  import imm_narrow_pkg::*;
#(
  parameter int IN_W = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int SATURATE = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  input  logic             clear_count,
  output logic [CNT_W-1:0] ovf_count
);
  logic [OUT_W:0] narrowed;
  logic hit;
  assign narrowed = narrow(in_data, SATURATE != 0);
  assign hit = in_valid & in_ready & narrowed[OUT_W];
  narrow_skid_buf #(.W(OUT_W + 1)) u_buf (
    .clk(clk),
    .reset_n(reset_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(narrowed),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data({out_ovf, out_data})
  );
  always_ff @(posedge clk) begin
    if (!reset_n) ovf_count <= '0;
    else if (clear_count) ovf_count <= {{(CNT_W-1){1'b0}}, hit};
    else if (hit && ovf_count != '1) ovf_count <= ovf_count + 1'b1;
  end
endmodule

// File: tb/tb_imm_narrow_16to6.sv
// tb_imm_narrow_16to6: directed and random checks of saturating and truncating instances.
module tb_imm_narrow_16to6;
  logic clk = 0, reset_n = 0, in_valid = 0, out_ready = 0, clear_count = 0;
  logic [15:0] in_data = '0;
  logic in_ready, out_valid, out_ovf, in_ready0, out_valid0, out_ovf0;
  logic [5:0] out_data, out_data0;
  logic [7:0] ovf_count, ovf_count0;
  int checks = 0, errors = 0, popped = 0, mcnt = 0;
  bit chk_en = 0;
  logic [6:0] q1[$], q0[$];

  imm_narrow_16to6 #(.SATURATE(1)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf),
    .clear_count(clear_count), .ovf_count(ovf_count));
  imm_narrow_16to6 #(.SATURATE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_ovf(out_ovf0),
    .clear_count(clear_count), .ovf_count(ovf_count0));

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_narrow(input logic [15:0] d, input bit sat);
    int v;
    v = int'($signed(d));
    if (v >= -32 && v <= 31) return {1'b0, 6'(v)};
    return {1'b1, sat ? (v > 0 ? 6'd31 : 6'h20) : 6'(v)};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: a queue of expected fields plus a saturating count.
  always @(posedge clk) begin
    bit push, pop, ovf;
    if (!reset_n) begin
      q1.delete();
      q0.delete();
      mcnt = 0;
    end else begin
      push = in_valid && q1.size() < 2;
      pop = out_ready && q1.size() > 0;
      ovf = ref_narrow(in_data, 1) >> 6;
      if (pop) begin
        void'(q1.pop_front());
        void'(q0.pop_front());
        popped++;
      end
      if (push) begin
        q1.push_back(ref_narrow(in_data, 1));
        q0.push_back(ref_narrow(in_data, 0));
      end
      if (clear_count) mcnt = (push && ovf) ? 1 : 0;
      else if (push && ovf && mcnt < 255) mcnt++;
    end
  end

  always @(negedge clk) if (chk_en) begin
    check("in_ready", 16'(in_ready), 16'(q1.size() < 2));
    check("out_valid", 16'(out_valid), 16'(q1.size() > 0));
    check("in_ready0", 16'(in_ready0), 16'(q0.size() < 2));
    check("out_valid0", 16'(out_valid0), 16'(q0.size() > 0));
    check("ovf_count", 16'(ovf_count), 16'(mcnt));
    check("ovf_count0", 16'(ovf_count0), 16'(mcnt));
    if (q1.size() > 0) check("head_sat", {9'd0, out_ovf, out_data}, {9'd0, q1[0]});
    if (q0.size() > 0) check("head_trunc", {9'd0, out_ovf0, out_data0}, {9'd0, q0[0]});
  end

  initial begin
    logic [15:0] vec[5] = '{16'h001F, 16'hFFE0, 16'h0020, 16'hFFDF, 16'h8000};
    logic [6:0] exp_sat[5] = '{7'h1F, 7'h20, 7'h5F, 7'h60, 7'h60};
    int cyc, r;
    check("model_fit_pos", 16'(ref_narrow(16'h001F, 1)), 16'h001F);
    check("model_sat_neg", 16'(ref_narrow(16'h8000, 1)), 16'h0060);
    check("model_trunc", 16'(ref_narrow(16'h0045, 0)), 16'h0045);
    check("model_trunc_neg", 16'(ref_narrow(16'hFFC1, 0)), 16'h0041);
    step();
    chk_en = 1;
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_in_ready", 16'(in_ready), 16'd1);
    check("rst_out_data", {9'd0, out_ovf, out_data}, 16'd0);
    check("rst_count", 16'(ovf_count), 16'd0);
    reset_n = 1;
    out_ready = 1;
    in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      in_data = vec[i];
      step();
      check("range_edge", {9'd0, out_ovf, out_data}, {9'd0, exp_sat[i]});
    end
    check("count_3", 16'(ovf_count), 16'd3);
    in_data = 16'h0045;
    step();
    check("trunc_45", {9'd0, out_ovf0, out_data0}, 16'h0045);
    check("sat_45", {9'd0, out_ovf, out_data}, 16'h005F);
    in_data = 16'hFFC1;
    step();
    check("trunc_ffc1", {9'd0, out_ovf0, out_data0}, 16'h0041);
    check("sat_ffc1", {9'd0, out_ovf, out_data}, 16'h0060);
    in_valid = 0;
    step();
    check("drained", 16'(out_valid), 16'd0);
    out_ready = 0;
    in_valid = 1;
    in_data = 16'd3;
    step();
    check("bp_a", {in_ready, out_valid, 8'd0, out_data}, 16'hC003);
    in_data = 16'hFFFC;
    step();
    check("bp_b_full", {in_ready, out_valid, 8'd0, out_data}, 16'h4003);
    in_data = 16'd7;
    step();
    check("bp_c_held", {in_ready, out_valid, 8'd0, out_data}, 16'h4003);
    out_ready = 1;
    step();
    check("bp_out_b", {in_ready, out_valid, 8'd0, out_data}, 16'hC03C);
    step();
    check("bp_out_c", {in_ready, out_valid, 8'd0, out_data}, 16'hC007);
    in_valid = 0;
    step();
    check("bp_empty", 16'(out_valid), 16'd0);
    clear_count = 1;
    step();
    check("clear", 16'(ovf_count), 16'd0);
    clear_count = 0;
    in_valid = 1;
    in_data = 16'h1000;
    repeat (300) step();
    check("count_sat", 16'(ovf_count), 16'd255);
    clear_count = 1;
    step();
    check("clear_with_ovf", 16'(ovf_count), 16'd1);
    clear_count = 0;
    out_ready = 0;
    in_data = 16'd1;
    step();
    step();
    check("pre_rst_full", 16'(in_ready), 16'd0);
    reset_n = 0;
    in_data = 16'd9;
    step();
    check("mid_rst", {in_ready, out_valid, 6'd0, ovf_count}, 16'h8000);
    reset_n = 1;
    in_data = 16'd5;
    step();
    check("post_rst", {in_ready, out_valid, 8'd0, out_data}, 16'hC005);
    in_valid = 0;
    out_ready = 1;
    step();
    popped = 0;
    cyc = 0;
    while (popped < 10000 && cyc < 40000) begin
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      clear_count = $urandom_range(0, 49) == 0;
      r = int'($urandom_range(0, 80)) - 40;
      in_data = $urandom_range(0, 1) ? 16'(r) : 16'($urandom);
      step();
      cyc++;
    end
    check("random_budget", 16'(popped >= 10000), 16'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
